// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into fixed-length high pulses separated by a
// forced low gap, queueing back-to-back triggers up to MAX_PENDING deep.
module pulse_stretcher #(
    parameter int WIDTH       = 8,
    parameter int GAP         = 2,
    parameter int RETRIGGER   = 0,
    parameter int MAX_PENDING = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               trig_in,
    output logic                               sig_out,
    output logic                               busy,
    output logic                               overflow,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending
);

    localparam int PW    = $clog2(MAX_PENDING + 1);
    localparam int MAXWG = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW    = $clog2(MAXWG + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_pending;
    logic            r_sig;
    logic            r_busy;
    logic            r_overflow;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [PW-1:0]   w_pending_nxt;
    logic            w_consume;
    logic            w_drop;
    logic            w_last;
    logic            w_retrig;
    logic            w_enq;
    logic            w_full;
    logic            w_have;

    assign w_last   = (r_cnt == CW'(1));
    assign w_retrig = (RETRIGGER != 0) && (r_state == S_HIGH) && trig_in;
    assign w_enq    = trig_in && (r_state != S_IDLE) && !w_retrig;
    assign w_full   = (r_pending == PW'(MAX_PENDING));
    // The queue is updated before the end-of-phase decision, so a trigger in
    // the final cycle already counts as a waiting pulse.
    assign w_have   = (r_pending != {PW{1'b0}}) || w_enq;

    // Next-state and counter selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_consume   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (trig_in) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = CW'(WIDTH);
                end else begin
                    w_cnt_nxt   = {CW{1'b0}};
                end
            end
            S_HIGH: begin
                if (w_retrig) begin
                    w_cnt_nxt = CW'(WIDTH);
                end else if (w_last) begin
                    if (!w_have) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = {CW{1'b0}};
                    end else if (GAP > 0) begin
                        w_state_nxt = S_LOW;
                        w_cnt_nxt   = CW'(GAP);
                    end else begin
                        w_cnt_nxt   = CW'(WIDTH);
                        w_consume   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_LOW: begin
                if (w_last) begin
                    if (w_have) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = CW'(WIDTH);
                        w_consume   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = {CW{1'b0}};
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // Queue bookkeeping; a consume in the same cycle absorbs the new trigger.
    always_comb begin
        w_pending_nxt = r_pending;
        w_drop        = 1'b0;
        if (w_enq && w_consume) begin
            w_pending_nxt = r_pending;
        end else if (w_consume) begin
            w_pending_nxt = r_pending - PW'(1);
        end else if (w_enq) begin
            if (w_full) begin
                w_drop = 1'b1;
            end else begin
                w_pending_nxt = r_pending + PW'(1);
            end
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // State, counter, queue and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CW{1'b0}};
            r_pending  <= {PW{1'b0}};
            r_sig      <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pending  <= w_pending_nxt;
            r_sig      <= (w_state_nxt == S_HIGH);
            r_busy     <= (w_state_nxt != S_IDLE) || (w_pending_nxt != {PW{1'b0}});
            r_overflow <= w_drop;
        end
    end

    assign sig_out  = r_sig;
    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign pending  = r_pending;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default, retrigger and zero-gap instances
// share clock and reset; expected waveforms are hand-derived cycle ranges.
module tb_pulse_stretcher;

    logic       clk;
    logic       reset;
    logic       trig_a, trig_r, trig_g;
    logic       sig_a, busy_a, ovf_a;
    logic       sig_r, busy_r, ovf_r;
    logic       sig_g, busy_g, ovf_g;
    logic [1:0] pend_a, pend_r, pend_g;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses;
    logic prev_sig;

    pulse_stretcher #(.WIDTH(8), .GAP(2), .RETRIGGER(0), .MAX_PENDING(3)) u_a (
        .clk(clk), .reset(reset), .trig_in(trig_a), .sig_out(sig_a),
        .busy(busy_a), .overflow(ovf_a), .pending(pend_a));

    pulse_stretcher #(.WIDTH(8), .GAP(2), .RETRIGGER(1), .MAX_PENDING(3)) u_r (
        .clk(clk), .reset(reset), .trig_in(trig_r), .sig_out(sig_r),
        .busy(busy_r), .overflow(ovf_r), .pending(pend_r));

    pulse_stretcher #(.WIDTH(8), .GAP(0), .RETRIGGER(0), .MAX_PENDING(3)) u_g (
        .clk(clk), .reset(reset), .trig_in(trig_g), .sig_out(sig_g),
        .busy(busy_g), .overflow(ovf_g), .pending(pend_g));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        trig_a = 1'b0;
        trig_r = 1'b0;
        trig_g = 1'b0;
        step();
        step();
        chk("rst sig_a", sig_a, 0);
        chk("rst busy_a", busy_a, 0);
        chk("rst ovf_a", ovf_a, 0);
        chk("rst pend_a", pend_a, 0);
        chk("rst sig_r", sig_r, 0);
        chk("rst sig_g", sig_g, 0);
        reset = 1'b0;
        step();

        // single trigger
        for (int c = 0; c <= 12; c++) begin
            trig_a = (c == 0);
            chk($sformatf("t1 sig c%0d", c), sig_a, (c >= 1 && c <= 8));
            chk($sformatf("t1 busy c%0d", c), busy_a, (c >= 1 && c <= 8));
            step();
        end

        // three back-to-back triggers, queued
        for (int c = 0; c <= 31; c++) begin
            trig_a = (c <= 2);
            chk($sformatf("t2 sig c%0d", c), sig_a,
                (c >= 1 && c <= 8) || (c >= 11 && c <= 18) || (c >= 21 && c <= 28));
            chk($sformatf("t2 busy c%0d", c), busy_a, (c >= 1 && c <= 28));
            chk($sformatf("t2 pend c%0d", c), pend_a,
                (c < 2) ? 0 : (c == 2) ? 1 : (c <= 10) ? 2 : (c <= 20) ? 1 : 0);
            step();
        end

        // five triggers: queue saturates, one overflow, four pulses
        pulses   = 0;
        prev_sig = 1'b0;
        for (int c = 0; c <= 41; c++) begin
            trig_a = (c <= 4);
            chk($sformatf("t3 ovf c%0d", c), ovf_a, (c == 5));
            chk($sformatf("t3 busy c%0d", c), busy_a, (c >= 1 && c <= 38));
            chk($sformatf("t3 pend c%0d", c), pend_a,
                (c <= 1) ? 0 : (c == 2) ? 1 : (c == 3) ? 2 : (c <= 10) ? 3 :
                (c <= 20) ? 2 : (c <= 30) ? 1 : 0);
            if (sig_a && !prev_sig) pulses++;
            prev_sig = sig_a;
            step();
        end
        chk("t3 pulse count", pulses, 4);

        // trigger in the last high cycle is queued, not lost
        for (int c = 0; c <= 21; c++) begin
            trig_a = (c == 0) || (c == 8);
            chk($sformatf("t7 sig c%0d", c), sig_a, (c >= 1 && c <= 8) || (c >= 11 && c <= 18));
            chk($sformatf("t7 busy c%0d", c), busy_a, (c >= 1 && c <= 18));
            chk($sformatf("t7 pend c%0d", c), pend_a, (c == 9 || c == 10));
            step();
        end

        // retrigger extends the running pulse
        for (int c = 0; c <= 16; c++) begin
            trig_r = (c == 0) || (c == 5);
            chk($sformatf("t4 sig c%0d", c), sig_r, (c >= 1 && c <= 13));
            chk($sformatf("t4 busy c%0d", c), busy_r, (c >= 1 && c <= 13));
            chk($sformatf("t4 pend c%0d", c), pend_r, 0);
            step();
        end

        // zero gap merges queued pulses
        for (int c = 0; c <= 19; c++) begin
            trig_g = (c <= 1);
            chk($sformatf("t5 sig c%0d", c), sig_g, (c >= 1 && c <= 16));
            chk($sformatf("t5 busy c%0d", c), busy_g, (c >= 1 && c <= 16));
            chk($sformatf("t5 pend c%0d", c), pend_g, (c >= 2 && c <= 8));
            step();
        end

        // reset mid-pulse with two queued; trigger during reset ignored
        for (int c = 0; c <= 15; c++) begin
            trig_a = (c <= 2) || (c == 4) || (c == 5);
            reset  = (c == 4) || (c == 5);
            if (c <= 4) begin
                chk($sformatf("t6 sig c%0d", c), sig_a, (c >= 1));
                chk($sformatf("t6 pend c%0d", c), pend_a,
                    (c <= 1) ? 0 : (c == 2) ? 1 : 2);
            end else begin
                chk($sformatf("t6 sig c%0d", c), sig_a, 0);
                chk($sformatf("t6 busy c%0d", c), busy_a, 0);
                chk($sformatf("t6 pend c%0d", c), pend_a, 0);
                chk($sformatf("t6 ovf c%0d", c), ovf_a, 0);
            end
            step();
        end
        trig_a = 1'b0;
        reset  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
